norflash_seq_driver: RTL and testbench

- Parametrised successor to the single-shot key-driven flash exerciser.
- One falling edge on k1_n runs a full self-checking sequence against the NOR flash controller: sector erase, BURST_LEN byte writes, then BURST_LEN read-backs compared against expected data.
- Sits between board key/LED logic and the flash controller command interface.
- Reports busy, pass/fail and a mismatch count.

---
 rtl/norflash_seq_driver_if.sv | 33 +++
 rtl/norflash_seq_driver.sv | 273 +++++++++++++++++++++++++++
 tb/tb_norflash_seq_driver.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/norflash_seq_driver_if.sv
// Command bus between the sequence driver (master) and the NOR flash controller (slave).
interface norflash_seq_driver_if #(
  parameter int unsigned ASIZE = 22,
  parameter int unsigned DSIZE = 8
);
  logic             flash_req_o;
  logic [2:0]       sys_cmd_o;
  logic [ASIZE-1:0] sys_rd_addr_o;
  logic [ASIZE-1:0] sys_wr_addr_o;
  logic [DSIZE-1:0] sys_wr_data_o;
  logic             flash_done_i;
  logic [DSIZE-1:0] flash_rd_data_i;

  modport master (
    output flash_req_o,
    output sys_cmd_o,
    output sys_rd_addr_o,
    output sys_wr_addr_o,
    output sys_wr_data_o,
    input  flash_done_i,
    input  flash_rd_data_i
  );

  modport slave (
    input  flash_req_o,
    input  sys_cmd_o,
    input  sys_rd_addr_o,
    input  sys_wr_addr_o,
    input  sys_wr_data_o,
    output flash_done_i,
    output flash_rd_data_i
  );
endinterface

// File: rtl/norflash_seq_driver.sv
// Key-triggered NOR flash self-test: sector erase, BURST_LEN writes, BURST_LEN verified reads.
// Optional per-command wait timeout enabled by defining NORFLASH_SEQ_TIMEOUT_EN.
module norflash_seq_driver #(
  parameter int unsigned ASIZE          = 22,
  parameter int unsigned DSIZE          = 8,
  parameter int unsigned SECTOR_LSB     = 13,
  parameter int unsigned BURST_LEN      = 4,
  parameter int unsigned DATA_SEED      = 'hCC,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        k1_n,
  input  logic [ASIZE-SECTOR_LSB-1:0] sector_i,
  norflash_seq_driver_if.master       flash_if,
  output logic                        busy_o,
  output logic                        pass_o,
  output logic                        fail_o,
  output logic [7:0]                  err_cnt_o,
  output logic                        timeout_o
);

  localparam int unsigned      IDX_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned      SEC_W    = ASIZE - SECTOR_LSB;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);
  localparam logic [DSIZE-1:0] SEED     = DSIZE'(DATA_SEED);

  localparam logic [2:0] CMD_READ  = 3'b000;
  localparam logic [2:0] CMD_WRITE = 3'b001;
  localparam logic [2:0] CMD_ERASE = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ER_REQ,
    S_ER_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_RD_REQ,
    S_RD_WAIT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic             r_k1_s1;
  logic             r_k1_s2;
  logic             r_k1_s3;
  logic [SEC_W-1:0] r_sector;
  logic [IDX_W-1:0] r_idx;
  logic             r_req;
  logic [2:0]       r_cmd;
  logic [ASIZE-1:0] r_rd_addr;
  logic [ASIZE-1:0] r_wr_addr;
  logic [DSIZE-1:0] r_wr_data;
  logic             r_busy;
  logic             r_pass;
  logic             r_fail;
  logic [7:0]       r_err;

  logic             w_start;
  logic             w_accept;
  logic [ASIZE-1:0] w_start_base;
  logic [ASIZE-1:0] w_base;
  logic [IDX_W-1:0] w_idx_next;
  logic [ASIZE-1:0] w_addr_next;
  logic [DSIZE-1:0] w_data_next;
  logic [DSIZE-1:0] w_expected;
  logic             w_last;
  logic             w_mismatch;
  logic [7:0]       w_err_upd;
  logic             w_wait_expired;

  // Key synchroniser plus one delay stage; start fires on the synchronised falling edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_k1_s1 <= 1'b1;
      r_k1_s2 <= 1'b1;
      r_k1_s3 <= 1'b1;
    end else begin
      r_k1_s1 <= k1_n;
      r_k1_s2 <= r_k1_s1;
      r_k1_s3 <= r_k1_s2;
    end
  end

  assign w_start  = ~r_k1_s2 & r_k1_s3;
  assign w_accept = w_start & ((r_state == S_IDLE) || (r_state == S_DONE));

  // The erase is issued on the same edge that latches the sector, so it uses sector_i directly.
  assign w_start_base = {sector_i, {SECTOR_LSB{1'b0}}};
  assign w_base       = {r_sector, {SECTOR_LSB{1'b0}}};
  assign w_idx_next   = r_idx + IDX_W'(1);
  assign w_addr_next  = w_base + ASIZE'(w_idx_next);
  assign w_data_next  = SEED + DSIZE'(w_idx_next);
  assign w_expected   = SEED + DSIZE'(r_idx);
  assign w_last       = (r_idx == LAST_IDX);
  assign w_mismatch   = (flash_if.flash_rd_data_i != w_expected);
  assign w_err_upd    = !w_mismatch     ? r_err :
                        (r_err == 8'hFF) ? r_err : r_err + 8'd1;

`ifdef NORFLASH_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;
  logic            w_in_wait;
  logic            w_in_req;

  assign w_in_wait = (r_state == S_ER_WAIT) || (r_state == S_WR_WAIT) || (r_state == S_RD_WAIT);
  assign w_in_req  = (r_state == S_ER_REQ)  || (r_state == S_WR_REQ)  || (r_state == S_RD_REQ);
  // A done arriving on the limit cycle takes priority over the timeout.
  assign w_wait_expired = w_in_wait && !flash_if.flash_done_i &&
                          (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_in_req) begin
        r_to_cnt <= '0;
      end else if (w_in_wait && !w_wait_expired) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
      if (w_accept) begin
        r_timeout <= 1'b0;
      end else if (w_wait_expired) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout_o = r_timeout;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

  assign w_wait_expired = 1'b0;
  assign timeout_o      = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= S_IDLE;
      r_sector  <= '0;
      r_idx     <= '0;
      r_req     <= 1'b0;
      r_cmd     <= CMD_READ;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_err     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_sector  <= sector_i;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_err     <= '0;
            r_busy    <= 1'b1;
            r_idx     <= '0;
            r_req     <= 1'b1;
            r_cmd     <= CMD_ERASE;
            r_wr_addr <= w_start_base;
            r_state   <= S_ER_REQ;
          end
        end

        S_ER_REQ: begin
          r_req   <= 1'b0;
          r_state <= S_ER_WAIT;
        end

        S_WR_REQ: begin
          r_req   <= 1'b0;
          r_state <= S_WR_WAIT;
        end

        S_RD_REQ: begin
          r_req   <= 1'b0;
          r_state <= S_RD_WAIT;
        end

        S_ER_WAIT: begin
          if (flash_if.flash_done_i) begin
            r_idx     <= '0;
            r_req     <= 1'b1;
            r_cmd     <= CMD_WRITE;
            r_wr_addr <= w_base;
            r_wr_data <= SEED;
            r_state   <= S_WR_REQ;
          end else if (w_wait_expired) begin
            r_cmd   <= CMD_READ;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_WR_WAIT: begin
          if (flash_if.flash_done_i) begin
            r_req <= 1'b1;
            if (w_last) begin
              r_idx     <= '0;
              r_cmd     <= CMD_READ;
              r_rd_addr <= w_base;
              r_state   <= S_RD_REQ;
            end else begin
              r_idx     <= w_idx_next;
              r_cmd     <= CMD_WRITE;
              r_wr_addr <= w_addr_next;
              r_wr_data <= w_data_next;
              r_state   <= S_WR_REQ;
            end
          end else if (w_wait_expired) begin
            r_cmd   <= CMD_READ;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_RD_WAIT: begin
          if (flash_if.flash_done_i) begin
            r_err <= w_err_upd;
            if (w_last) begin
              r_cmd   <= CMD_READ;
              r_busy  <= 1'b0;
              r_pass  <= (w_err_upd == 8'd0);
              r_fail  <= (w_err_upd != 8'd0);
              r_state <= S_DONE;
            end else begin
              r_idx     <= w_idx_next;
              r_req     <= 1'b1;
              r_cmd     <= CMD_READ;
              r_rd_addr <= w_addr_next;
              r_state   <= S_RD_REQ;
            end
          end else if (w_wait_expired) begin
            r_cmd   <= CMD_READ;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        default: begin
          r_req   <= 1'b0;
          r_cmd   <= CMD_READ;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign flash_if.flash_req_o   = r_req;
  assign flash_if.sys_cmd_o     = r_cmd;
  assign flash_if.sys_rd_addr_o = r_rd_addr;
  assign flash_if.sys_wr_addr_o = r_wr_addr;
  assign flash_if.sys_wr_data_o = r_wr_data;

  assign busy_o    = r_busy;
  assign pass_o    = r_pass;
  assign fail_o    = r_fail;
  assign err_cnt_o = r_err;

endmodule

// File: tb/tb_norflash_seq_driver.sv
// Directed bench: two driver instances (default and seed FE / burst 3) against behavioural controllers.
`timescale 1ns/1ps
module tb_norflash_seq_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       k1a_n;
  logic       k1b_n;
  logic [8:0] sec_a;
  logic [8:0] sec_b;

  logic       busy_a, pass_a, fail_a, to_a;
  logic [7:0] err_a;
  logic       busy_b, pass_b, fail_b, to_b;
  logic [7:0] err_b;

  int checks = 0;
  int errors = 0;

  norflash_seq_driver_if #(.ASIZE(22), .DSIZE(8)) fa ();
  norflash_seq_driver_if #(.ASIZE(22), .DSIZE(8)) fb ();

  norflash_seq_driver #(.TIMEOUT_CYCLES(20)) dut_a (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .k1_n      (k1a_n),
    .sector_i  (sec_a),
    .flash_if  (fa),
    .busy_o    (busy_a),
    .pass_o    (pass_a),
    .fail_o    (fail_a),
    .err_cnt_o (err_a),
    .timeout_o (to_a)
  );

  norflash_seq_driver #(.DATA_SEED('hFE), .BURST_LEN(3)) dut_b (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .k1_n      (k1b_n),
    .sector_i  (sec_b),
    .flash_if  (fb),
    .busy_o    (busy_b),
    .pass_o    (pass_b),
    .fail_o    (fail_b),
    .err_cnt_o (err_b),
    .timeout_o (to_b)
  );

  always #5 clk = ~clk;

  // Controller model A: logs every request, answers 5 cycles later, echoes written data.
  logic [2:0]  la_cmd  [256];
  logic [21:0] la_addr [256];
  logic [7:0]  la_data [256];
  int          la_n = 0;
  logic [7:0]  mem_a [int];
  int          ra_cnt = 0;
  logic [2:0]  ra_cmd;
  logic [21:0] ra_addr;
  logic [7:0]  ra_data;
  int          corrupt_a = -1;
  bit          mute_a = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      ra_cnt = 0;
      fa.flash_done_i = 1'b0;
      fa.flash_rd_data_i = 8'h00;
    end else begin
      fa.flash_done_i = 1'b0;
      if (fa.flash_req_o) begin
        ra_cmd  = fa.sys_cmd_o;
        ra_addr = (fa.sys_cmd_o == 3'b000) ? fa.sys_rd_addr_o : fa.sys_wr_addr_o;
        ra_data = fa.sys_wr_data_o;
        if (la_n < 256) begin
          la_cmd[la_n]  = ra_cmd;
          la_addr[la_n] = ra_addr;
          la_data[la_n] = ra_data;
        end
        la_n++;
        if (!mute_a) ra_cnt = 5;
      end else if (ra_cnt > 0) begin
        ra_cnt--;
        if (ra_cnt == 0) begin
          case (ra_cmd)
            3'b010:  mem_a.delete();
            3'b001:  mem_a[int'(ra_addr)] = ra_data;
            default: fa.flash_rd_data_i = (int'(ra_addr) == corrupt_a) ? 8'h00 :
                                          mem_a.exists(int'(ra_addr)) ? mem_a[int'(ra_addr)] : 8'hFF;
          endcase
          fa.flash_done_i = 1'b1;
        end
      end
    end
  end

  // Controller model B: 2-cycle latency, records write data.
  logic [7:0]  mem_b [int];
  logic [7:0]  wb_data [8];
  int          wb_n = 0;
  int          b_n = 0;
  int          rb_cnt = 0;
  logic [2:0]  rb_cmd;
  logic [21:0] rb_addr;
  logic [7:0]  rb_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      rb_cnt = 0;
      fb.flash_done_i = 1'b0;
      fb.flash_rd_data_i = 8'h00;
    end else begin
      fb.flash_done_i = 1'b0;
      if (fb.flash_req_o) begin
        rb_cmd  = fb.sys_cmd_o;
        rb_addr = (fb.sys_cmd_o == 3'b000) ? fb.sys_rd_addr_o : fb.sys_wr_addr_o;
        rb_data = fb.sys_wr_data_o;
        b_n++;
        if (rb_cmd == 3'b001 && wb_n < 8) begin
          wb_data[wb_n] = rb_data;
          wb_n++;
        end
        rb_cnt = 2;
      end else if (rb_cnt > 0) begin
        rb_cnt--;
        if (rb_cnt == 0) begin
          case (rb_cmd)
            3'b010:  mem_b.delete();
            3'b001:  mem_b[int'(rb_addr)] = rb_data;
            default: fb.flash_rd_data_i = mem_b.exists(int'(rb_addr)) ? mem_b[int'(rb_addr)] : 8'hFF;
          endcase
          fb.flash_done_i = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input int which);
    if (which == 0) k1a_n = 1'b0; else k1b_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    if (which == 0) k1a_n = 1'b1; else k1b_n = 1'b1;
  endtask

  task automatic wait_idle(input int which, input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      #1;
      if (which == 0 && !busy_a) ok = 1'b1;
      if (which == 1 && !busy_b) ok = 1'b1;
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_reqs(input int target, input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      #1;
      if (la_n >= target) ok = 1'b1;
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  logic [7:0] exp_wd [4];
  logic [7:0] exp_b  [3];
  int base;

  initial begin
    exp_wd = '{8'hCC, 8'hCD, 8'hCE, 8'hCF};
    exp_b  = '{8'hFE, 8'hFF, 8'h00};
    rst_n = 1'b0;
    k1a_n = 1'b1;
    k1b_n = 1'b1;
    sec_a = 9'd0;
    sec_b = 9'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  32'(busy_a), 32'd0);
    chk("rst_pass",  32'(pass_a), 32'd0);
    chk("rst_fail",  32'(fail_a), 32'd0);
    chk("rst_err",   32'(err_a), 32'd0);
    chk("rst_to",    32'(to_a), 32'd0);
    chk("rst_req",   32'(fa.flash_req_o), 32'd0);
    chk("rst_cmd",   32'(fa.sys_cmd_o), 32'd0);
    chk("rst_waddr", 32'(fa.sys_wr_addr_o), 32'd0);
    chk("rst_wdata", 32'(fa.sys_wr_data_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Nominal run, sector 1, including first-request latency.
    sec_a = 9'd1;
    base = la_n;
    k1a_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("req_before_3rd_edge", 32'(fa.flash_req_o), 32'd0);
    @(posedge clk);
    #1;
    chk("req_at_3rd_edge", 32'(fa.flash_req_o), 32'd1);
    chk("erase_cmd_live",  32'(fa.sys_cmd_o), 32'd2);
    chk("erase_addr_live", 32'(fa.sys_wr_addr_o), 32'h2000);
    chk("busy_running",    32'(busy_a), 32'd1);
    @(posedge clk);
    #1;
    chk("req_one_cycle", 32'(fa.flash_req_o), 32'd0);
    k1a_n = 1'b1;
    wait_idle(0, 400, "run1_complete");
    chk("run1_req_count", 32'(la_n - base), 32'd9);
    chk("run1_er_cmd",  32'(la_cmd[base]), 32'd2);
    chk("run1_er_addr", 32'(la_addr[base]), 32'h2000);
    for (int k = 0; k < 4; k++) begin
      chk("run1_wr_cmd",  32'(la_cmd[base+1+k]), 32'd1);
      chk("run1_wr_addr", 32'(la_addr[base+1+k]), 32'h2000 + 32'(k));
      chk("run1_wr_data", 32'(la_data[base+1+k]), 32'(exp_wd[k]));
      chk("run1_rd_cmd",  32'(la_cmd[base+5+k]), 32'd0);
      chk("run1_rd_addr", 32'(la_addr[base+5+k]), 32'h2000 + 32'(k));
    end
    chk("run1_pass", 32'(pass_a), 32'd1);
    chk("run1_fail", 32'(fail_a), 32'd0);
    chk("run1_err",  32'(err_a), 32'd0);
    chk("run1_cmd_idle", 32'(fa.sys_cmd_o), 32'd0);

    // Second byte reads back as 00.
    corrupt_a = 'h2001;
    base = la_n;
    press(0);
    wait_idle(0, 400, "run2_complete");
    chk("run2_req_count", 32'(la_n - base), 32'd9);
    chk("run2_err",  32'(err_a), 32'd1);
    chk("run2_fail", 32'(fail_a), 32'd1);
    chk("run2_pass", 32'(pass_a), 32'd0);
    corrupt_a = -1;

    // Press after DONE clears flags; a press during WR_WAIT is ignored.
    base = la_n;
    press(0);
    chk("run3_flags_cleared_fail", 32'(fail_a), 32'd0);
    chk("run3_flags_cleared_err",  32'(err_a), 32'd0);
    wait_reqs(base + 2, 100, "run3_reach_write");
    press(0);
    wait_idle(0, 400, "run3_complete");
    chk("run3_req_count", 32'(la_n - base), 32'd9);
    chk("run3_pass", 32'(pass_a), 32'd1);

    // Asynchronous reset during RD_WAIT, then restart from erase in sector 2.
    base = la_n;
    press(0);
    wait_reqs(base + 7, 200, "run4_reach_read");
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy",  32'(busy_a), 32'd0);
    chk("arst_req",   32'(fa.flash_req_o), 32'd0);
    chk("arst_cmd",   32'(fa.sys_cmd_o), 32'd0);
    chk("arst_raddr", 32'(fa.sys_rd_addr_o), 32'd0);
    chk("arst_waddr", 32'(fa.sys_wr_addr_o), 32'd0);
    chk("arst_pass",  32'(pass_a), 32'd0);
    chk("arst_fail",  32'(fail_a), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("arst_stays_idle", 32'(busy_a), 32'd0);
    sec_a = 9'd2;
    base = la_n;
    press(0);
    wait_idle(0, 400, "run5_complete");
    chk("run5_first_cmd",  32'(la_cmd[base]), 32'd2);
    chk("run5_first_addr", 32'(la_addr[base]), 32'h4000);
    chk("run5_last_rd_addr", 32'(la_addr[base+8]), 32'h4003);
    chk("run5_pass", 32'(pass_a), 32'd1);

    // Seed FE, burst 3: write data wraps through 00.
    press(1);
    wait_idle(1, 300, "runb_complete");
    chk("runb_req_count", 32'(b_n), 32'd7);
    chk("runb_wr_count",  32'(wb_n), 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk("runb_wr_data", 32'(wb_data[k]), 32'(exp_b[k]));
    end
    chk("runb_pass", 32'(pass_b), 32'd1);
    chk("runb_err",  32'(err_b), 32'd0);

    // Controller never answers the erase.
    mute_a = 1'b1;
`ifdef NORFLASH_SEQ_TIMEOUT_EN
    press(0);
    repeat (19) @(posedge clk);
    #1;
    chk("to_still_waiting", 32'(busy_a), 32'd1);
    chk("to_not_yet",       32'(to_a), 32'd0);
    @(posedge clk);
    #1;
    chk("to_busy",    32'(busy_a), 32'd0);
    chk("to_timeout", 32'(to_a), 32'd1);
    chk("to_fail",    32'(fail_a), 32'd1);
    chk("to_pass",    32'(pass_a), 32'd0);
`else
    press(0);
    repeat (40) @(posedge clk);
    #1;
    chk("nto_busy",    32'(busy_a), 32'd1);
    chk("nto_timeout", 32'(to_a), 32'd0);
    chk("nto_req",     32'(fa.flash_req_o), 32'd0);
    chk("nto_cmd_held", 32'(fa.sys_cmd_o), 32'd2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`endif
    mute_a = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
